instr_sequencer: RTL

- Upstream fetch/control stage for the 8-bit CPU ALU.
- Holds a small user-loaded program memory of 18-bit instructions and an 8x8 register file.
- Steps through the program one instruction at a time:
  - presents each instruction to the ALU;
  - pulses the ALU's operate strobe;
  - writes the ALU's result0..result7 back into the register file.
- Instruction format: [17:14] opCode, [13:11] regID1, [10:8] regID2, [7:0] immValue.

---
 rtl/instr_sequencer.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/instr_sequencer.sv
// Fetch/control stage for the 8-bit ALU: owns the program memory and register file,
// issues one instruction at a time and writes all eight ALU results back.
module instr_sequencer #(
  parameter int         PROG_DEPTH = 10,
  parameter int         INSTR_W    = 18,
  parameter int         DATA_W     = 8,
  parameter logic [3:0] HALT_OP    = 4'b1111
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               prog_we,
  input  logic [3:0]         prog_addr,
  input  logic [INSTR_W-1:0] prog_data,
  input  logic               reg_we,
  input  logic [2:0]         reg_sel,
  input  logic [DATA_W-1:0]  reg_wdata,
  input  logic               start,
  input  logic [DATA_W-1:0]  result0,
  input  logic [DATA_W-1:0]  result1,
  input  logic [DATA_W-1:0]  result2,
  input  logic [DATA_W-1:0]  result3,
  input  logic [DATA_W-1:0]  result4,
  input  logic [DATA_W-1:0]  result5,
  input  logic [DATA_W-1:0]  result6,
  input  logic [DATA_W-1:0]  result7,
  output logic [INSTR_W-1:0] instruction,
  output logic               operate,
  output logic [DATA_W-1:0]  reg0,
  output logic [DATA_W-1:0]  reg1,
  output logic [DATA_W-1:0]  reg2,
  output logic [DATA_W-1:0]  reg3,
  output logic [DATA_W-1:0]  reg4,
  output logic [DATA_W-1:0]  reg5,
  output logic [DATA_W-1:0]  reg6,
  output logic [DATA_W-1:0]  reg7,
  output logic [3:0]         pc,
  output logic               busy,
  output logic               done
);

  typedef enum logic [2:0] {IDLE, FETCH, EXEC, WB, DONE} state_e;

  localparam logic [3:0]         LAST_ADDR = 4'(PROG_DEPTH - 1);
  localparam logic [INSTR_W-1:0] HALT_WORD = {HALT_OP, (INSTR_W - 4)'(0)};

  state_e             state_q;
  logic [3:0]         pc_q;
  logic [INSTR_W-1:0] instr_q;
  logic               operate_q;
  logic               busy_q;
  logic               done_q;
  logic [DATA_W-1:0]  regs_q [8];
  logic [INSTR_W-1:0] mem_q  [PROG_DEPTH];

  logic [DATA_W-1:0]  results [8];
  logic [INSTR_W-1:0] fetchWord;

  assign results[0] = result0;
  assign results[1] = result1;
  assign results[2] = result2;
  assign results[3] = result3;
  assign results[4] = result4;
  assign results[5] = result5;
  assign results[6] = result6;
  assign results[7] = result7;

  assign fetchWord = mem_q[pc_q];

  // Memory and register file are only writable from IDLE, so a running program
  // cannot be disturbed by host writes.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      instr_q   <= '0;
      operate_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      for (int i = 0; i < 8; i++) regs_q[i] <= '0;
      for (int i = 0; i < PROG_DEPTH; i++) mem_q[i] <= HALT_WORD;
    end else begin
      case (state_q)
        IDLE: begin
          if (prog_we && (prog_addr <= LAST_ADDR)) mem_q[prog_addr] <= prog_data;
          if (reg_we) regs_q[reg_sel] <= reg_wdata;
          if (start) begin
            state_q <= FETCH;
            pc_q    <= '0;
            busy_q  <= 1'b1;
          end
        end
        FETCH: begin
          if (fetchWord[INSTR_W-1 -: 4] == HALT_OP) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            instr_q   <= fetchWord;
            operate_q <= 1'b1;
            state_q   <= EXEC;
          end
        end
        EXEC: begin
          operate_q <= 1'b0;
          state_q   <= WB;
        end
        WB: begin
          regs_q <= results;
          if (pc_q == LAST_ADDR) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            pc_q    <= pc_q + 4'd1;
            state_q <= FETCH;
          end
        end
        DONE: begin
          if (!start) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign instruction = instr_q;
  assign operate     = operate_q;
  assign pc          = pc_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign reg0        = regs_q[0];
  assign reg1        = regs_q[1];
  assign reg2        = regs_q[2];
  assign reg3        = regs_q[3];
  assign reg4        = regs_q[4];
  assign reg5        = regs_q[5];
  assign reg6        = regs_q[6];
  assign reg7        = regs_q[7];

endmodule
